// File: rtl/trace_monitor.sv
// trace_monitor: cycle-exact commit-trace recorder for the single-cycle core.
// Captures {pc, inst, wb_addr, wen, wb_data} into a DEPTH-entry FIFO that is
// drained through a valid/ready port. Capture ends on exit, on the watchdog,
// or (stop-when-full mode) on the first commit that finds the buffer full.
module trace_monitor #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 16,
    parameter int MODE    = 0,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       commit,
    input  logic [XLEN-1:0]            pc_reg,
    input  logic [XLEN-1:0]            inst,
    input  logic [4:0]                 wb_addr,
    input  logic                       wen,
    input  logic [XLEN-1:0]            wb_data,
    input  logic                       exit,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [3*XLEN+5:0]          rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       stopped,
    output logic                       timeout,
    output logic [CNT_W-1:0]           cycles
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = 3*XLEN+6;
    localparam logic [CW-1:0]    FULL    = CW'(DEPTH);
    localparam bit               WD_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT-1);

    typedef enum logic {CAPTURE, STOPPED} state_t;

    state_t        state;
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          capturing, full, pop, drop, push, overwrite, wd_fire;

    assign capturing = (state == CAPTURE);
    assign full      = (count == FULL);
    assign rd_valid  = (count != '0);
    assign rd_data   = mem[rp];
    assign pop       = rd_valid && rd_ready;
    // Stop-when-full: a commit that finds no room (and no pop freeing a slot) is lost.
    assign drop      = capturing && commit && (MODE == 0) && full && !pop;
    assign push      = capturing && commit && !drop;
    // Ring mode: pushing into a full buffer with no pop evicts the oldest entry.
    assign overwrite = push && full && !pop;
    // Watchdog fires on the last capture cycle; that cycle's commit still lands.
    assign wd_fire   = WD_EN && capturing && (cycles == WD_LAST);

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {pc_reg, inst, wb_addr, wen, wb_data};
    end

    // Pointers, occupancy and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)             wp <= wp + 1'b1;
            if (pop || overwrite) rp <= rp + 1'b1;
            if (push && !pop && !overwrite) count <= count + 1'b1;
            else if (pop && !push)          count <= count - 1'b1;
            if (drop || overwrite) overflow <= 1'b1;
        end
    end

    // Capture FSM with registered status outputs and saturating cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CAPTURE;
            stopped <= 1'b0;
            timeout <= 1'b0;
            cycles  <= '0;
        end else begin
            case (state)
                CAPTURE: begin
                    if (cycles != '1) cycles <= cycles + 1'b1;
                    if (exit || wd_fire || drop) begin
                        state   <= STOPPED;
                        stopped <= 1'b1;
                    end
                    if (wd_fire) timeout <= 1'b1;
                end
                default: begin
                    state   <= STOPPED;
                    stopped <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_monitor.sv
// tb_trace_monitor: directed bench for trace_monitor. Four instances cover the
// default build, stop-when-full and ring modes at DEPTH=4, and an 8-cycle
// watchdog. Expected entries go into a scoreboard queue as commits are driven
// and are popped and compared as the selected instance offers them.
module tb_trace_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        commit, wen, exit_s, rd_ready;
    logic [31:0] pc_reg, inst, wb_data;
    logic [4:0]  wb_addr;

    logic         v [4];
    logic [101:0] d [4];
    logic         ov [4];
    logic         st [4];
    logic         to [4];
    logic [31:0]  cy [4];
    logic [4:0]   c0, c3;
    logic [2:0]   c1, c2;

    int sel;
    logic         s_v, s_ov, s_st, s_to;
    logic [101:0] s_d;
    logic [4:0]   s_c;
    logic [31:0]  s_cy;

    int checks = 0;
    int failures = 0;
    logic [101:0] q [$];

    always #5 clk = ~clk;

    trace_monitor u0 (.clk(clk), .rst_n(rst_n), .commit(commit), .pc_reg(pc_reg), .inst(inst),
        .wb_addr(wb_addr), .wen(wen), .wb_data(wb_data), .exit(exit_s), .rd_ready(rd_ready),
        .rd_valid(v[0]), .rd_data(d[0]), .count(c0), .overflow(ov[0]), .stopped(st[0]),
        .timeout(to[0]), .cycles(cy[0]));
    trace_monitor #(.DEPTH(4), .MODE(0), .TIMEOUT(0)) u1 (.clk(clk), .rst_n(rst_n), .commit(commit),
        .pc_reg(pc_reg), .inst(inst), .wb_addr(wb_addr), .wen(wen), .wb_data(wb_data), .exit(exit_s),
        .rd_ready(rd_ready), .rd_valid(v[1]), .rd_data(d[1]), .count(c1), .overflow(ov[1]),
        .stopped(st[1]), .timeout(to[1]), .cycles(cy[1]));
    trace_monitor #(.DEPTH(4), .MODE(1), .TIMEOUT(0)) u2 (.clk(clk), .rst_n(rst_n), .commit(commit),
        .pc_reg(pc_reg), .inst(inst), .wb_addr(wb_addr), .wen(wen), .wb_data(wb_data), .exit(exit_s),
        .rd_ready(rd_ready), .rd_valid(v[2]), .rd_data(d[2]), .count(c2), .overflow(ov[2]),
        .stopped(st[2]), .timeout(to[2]), .cycles(cy[2]));
    trace_monitor #(.DEPTH(16), .MODE(0), .TIMEOUT(8)) u3 (.clk(clk), .rst_n(rst_n), .commit(commit),
        .pc_reg(pc_reg), .inst(inst), .wb_addr(wb_addr), .wen(wen), .wb_data(wb_data), .exit(exit_s),
        .rd_ready(rd_ready), .rd_valid(v[3]), .rd_data(d[3]), .count(c3), .overflow(ov[3]),
        .stopped(st[3]), .timeout(to[3]), .cycles(cy[3]));

    // Route the instance under test onto one set of observation signals.
    always_comb begin
        s_v  = v[0];  s_d  = d[0];  s_ov = ov[0];
        s_st = st[0]; s_to = to[0]; s_cy = cy[0]; s_c = c0;
        case (sel)
            1: begin s_v = v[1]; s_d = d[1]; s_ov = ov[1]; s_st = st[1]; s_to = to[1]; s_cy = cy[1]; s_c = {2'b0, c1}; end
            2: begin s_v = v[2]; s_d = d[2]; s_ov = ov[2]; s_st = st[2]; s_to = to[2]; s_cy = cy[2]; s_c = {2'b0, c2}; end
            3: begin s_v = v[3]; s_d = d[3]; s_ov = ov[3]; s_st = st[3]; s_to = to[3]; s_cy = cy[3]; s_c = c3; end
            default: ;
        endcase
    end

    function automatic logic [101:0] mk(input logic [31:0] p, input logic [31:0] dd);
        return {p, 32'h0000_0013, 5'd1, 1'b1, dd};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic c, input logic [31:0] p, input logic [31:0] dd, input logic e);
        commit  = c;
        pc_reg  = p;
        wb_data = dd;
        exit_s  = e;
    endtask

    // Compare the offered head entry with the scoreboard front and retire it.
    task automatic head(input string tag);
        if (q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s: observed entry %0h expected none", tag, s_d);
        end else begin
            chk({tag, "_valid"}, s_v, 1'b1);
            chk(tag, s_d, q.pop_front());
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        rd_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        q.delete();
    endtask

    // Drain with rd_ready held; bounded so a stuck rd_valid shows as a failure.
    task automatic drain(input string tag);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        rd_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (!s_v) break;
            head(tag);
            tick();
        end
        chk({tag, "_left"}, q.size(), 0);
        chk({tag, "_valid_end"}, s_v, 1'b0);
        rd_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] frozen;
        bit m_stop;
        inst = 32'h0000_0013;
        wb_addr = 5'd1;
        wen = 1'b1;
        sel = 0;
        rst_n = 1'b1;
        tick();

        // Reset state and basic capture.
        do_reset();
        chk("rst_count", s_c, 0);
        chk("rst_valid", s_v, 1'b0);
        chk("rst_overflow", s_ov, 1'b0);
        chk("rst_stopped", s_st, 1'b0);
        chk("rst_timeout", s_to, 1'b0);
        chk("rst_cycles", s_cy, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(4*i), 32'(i+1), 1'b0);
            q.push_back(mk(32'(4*i), 32'(i+1)));
            tick();
            if (i == 0) begin
                chk("lat1_valid", s_v, 1'b1);
                chk("lat1_data", s_d, mk(32'h0, 32'h1));
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("basic_count", s_c, 3);
        drain("basic_drain");

        // Stop-when-full at DEPTH=4.
        sel = 1;
        do_reset();
        m_stop = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'(4*i), 32'(i+1), 1'b0);
            if (!m_stop) begin
                if (q.size() < 4) q.push_back(mk(32'(4*i), 32'(i+1)));
                else m_stop = 1;
            end
            tick();
            if (i == 3) chk("m0_stop_before", s_st, 1'b0);
            if (i == 4) chk("m0_stop_5th", s_st, 1'b1);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("m0_count", s_c, 4);
        chk("m0_overflow", s_ov, 1'b1);
        drain("m0_drain");

        // Ring mode at DEPTH=4.
        sel = 2;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'(4*i), 32'(i+1), 1'b0);
            q.push_back(mk(32'(4*i), 32'(i+1)));
            if (q.size() > 4) void'(q.pop_front());
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("m1_count", s_c, 4);
        chk("m1_overflow", s_ov, 1'b1);
        chk("m1_stopped", s_st, 1'b0);
        drain("m1_drain");

        // Streaming push/pop, then exit on pc 0x20.
        sel = 0;
        do_reset();
        rd_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                chk("stream_count", s_c, 1);
                head("stream_head");
            end
            drive(1'b1, 32'(4*i), 32'(i+1), i == 8);
            q.push_back(mk(32'(4*i), 32'(i+1)));
            tick();
        end
        chk("exit_stopped", s_st, 1'b1);
        chk("exit_count", s_c, 1);
        chk("exit_cycles", s_cy, 9);
        chk("exit_entry", s_d, mk(32'h20, 32'h9));
        frozen = s_cy;
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(4*i), 32'h55, 1'b0);
            tick();
        end
        chk("post_exit_count", s_c, 1);
        chk("post_exit_cycles", s_cy, frozen);
        drain("exit_drain");

        // Watchdog after 8 capture cycles.
        sel = 3;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(4*i), 32'(i+1), 1'b0);
            if (i < 8) q.push_back(mk(32'(4*i), 32'(i+1)));
            tick();
            if (i == 6) begin
                chk("wd_cyc7", s_cy, 7);
                chk("wd_stop_early", s_st, 1'b0);
                chk("wd_to_early", s_to, 1'b0);
            end
            if (i == 7) begin
                chk("wd_cyc8", s_cy, 8);
                chk("wd_stopped", s_st, 1'b1);
                chk("wd_timeout", s_to, 1'b1);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("wd_count", s_c, 8);
        chk("wd_cycles_hold", s_cy, 8);
        chk("wd_overflow", s_ov, 1'b0);
        drain("wd_drain");

        // Asynchronous reset between edges.
        sel = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(4*i), 32'(i+1), i == 4);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("ar_count_pre", s_c, 5);
        chk("ar_stopped_pre", s_st, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_count", s_c, 0);
        chk("ar_valid", s_v, 1'b0);
        chk("ar_stopped", s_st, 1'b0);
        chk("ar_overflow", s_ov, 1'b0);
        chk("ar_timeout", s_to, 1'b0);
        chk("ar_cycles", s_cy, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h40 + 32'(4*i), 32'(i+7), 1'b0);
            q.push_back(mk(32'h40 + 32'(4*i), 32'(i+7)));
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("ar_resume_count", s_c, 2);
        drain("ar_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
